// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory stages, the issue hazard logic
// and the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_rd;
  logic [ADDR_W-1:0] chk_rs;
  logic [ADDR_W-1:0] chk_rt;
  logic              rs_busy;
  logic              rt_busy;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;

  // Pipeline-stage side: issues requests, reservations and hazard lookups.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output rsv_en, rsv_rd, chk_rs, chk_rt,
    input  alu_ready, mem_ready, rs_busy, rt_busy,
    input  rf_we, rf_wa, rf_wd
  );

  // Arbiter side: grants requests and drives the register file write port.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  rsv_en, rsv_rd, chk_rs, chk_rt,
    output alu_ready, mem_ready, rs_busy, rt_busy,
    output rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port (ALU vs load data)
// with a per-register busy scoreboard for RAW hazard detection.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {GNT_ALU, GNT_MEM} grant_e;

  grant_e            last_grant;
  logic              grant_alu;
  logic              grant_mem;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_wa_q;
  logic [DATA_W-1:0] rf_wd_q;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so the block reads top-down and no latch can be inferred.
  always_comb begin
    grant_alu = bus.alu_valid && (!bus.mem_valid || last_grant == GNT_MEM);
    grant_mem = bus.mem_valid && !grant_alu;
    xfer      = grant_alu || grant_mem;
    sel_rd    = grant_alu ? bus.alu_rd   : bus.mem_rd;
    sel_data  = grant_alu ? bus.alu_data : bus.mem_data;
  end

  // Clear is applied before set so a reservation on the retiring edge wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_we_q)    busy_nxt[rf_wa_q]    = 1'b0;
    if (bus.rsv_en) busy_nxt[bus.rsv_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the scoreboard is a flop vector, not a RAM, and must be reset so no
  // phantom hazard stalls issue after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_MEM;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
      busy       <= '0;
    end else begin
      busy    <= busy_nxt;
      rf_we_q <= xfer && (sel_rd != '0);
      if (xfer) begin
        last_grant <= grant_alu ? GNT_ALU : GNT_MEM;
        rf_wa_q    <= sel_rd;
        rf_wd_q    <= sel_data;
      end
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wa     = rf_wa_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.rs_busy   = busy[bus.chk_rs];
  assign bus.rt_busy   = busy[bus.chk_rt];
endmodule
